// File: rtl/add_round_key_stage.sv
// AddRoundKey pipeline stage: XORs each incoming AES state with the next round key
// taken in order from a small key FIFO; registered output with valid/ready flow control.
module add_round_key_stage #(
  parameter int DATA_W    = 128,
  parameter int KEY_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       ready_out,
  input  logic                       key_valid,
  input  logic [DATA_W-1:0]          key_in,
  output logic                       key_ready,
  output logic [$clog2(KEY_DEPTH):0] key_count,
  output logic                       valid_out,
  output logic [DATA_W-1:0]          data_out,
  input  logic                       ready_in
);

  localparam int PTR_W = $clog2(KEY_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(KEY_DEPTH);

  if (KEY_DEPTH < 2 || (KEY_DEPTH & (KEY_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("KEY_DEPTH must be a power of 2 and at least 2");
  end

  // Every interface uses the same rule: a beat transfers on a rising edge where the
  // sender's valid and the receiver's ready are both high; a sender holds valid and
  // data stable until that happens, and ready never depends on the partner's valid.

  logic [DATA_W-1:0] key_mem [KEY_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // No pass-through when full: a pop in the same cycle does not open a slot.
  assign key_ready = (key_count < DEPTH_C);
  assign ready_out = (key_count != '0) && (!valid_out || ready_in);
  assign push      = key_valid && key_ready;
  assign pop       = valid_in && ready_out;

  always_ff @(posedge clk) begin
    if (reset && push) begin
      key_mem[wr_ptr] <= key_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      key_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   key_count <= key_count + CNT_W'(1);
        2'b01:   key_count <= key_count - CNT_W'(1);
        default: key_count <= key_count;
      endcase
    end
  end

  // data_out keeps its last value after a drain so a late observer still sees it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (pop) begin
      valid_out <= 1'b1;
      data_out  <= data_in ^ key_mem[rd_ptr];
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule
